// File: rtl/amax10_qsys_ledr_seq_pkg.sv
// Shared constants and types for the Avalon-MM LED sequencer.
// Register map, CTRL bit positions, FSM states and the default step period.
package amax10_qsys_ledr_seq_pkg;

    localparam int unsigned PERIOD_WIDTH = 24;
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_RESET_DEFAULT = 24'h4C4B3F;

    localparam logic [1:0] ADDR_PATTERN = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int unsigned CTRL_RUN   = 0;
    localparam int unsigned CTRL_MODE  = 1;
    localparam int unsigned CTRL_WIDTH = 2;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRunLeft  = 2'd1,
        StRunRight = 2'd2
    } state_e;

endpackage

// File: rtl/amax10_qsys_ledr_seq_tick.sv
// Step-rate down-counter: one step pulse every period+1 enabled cycles.
// A load restarts the count and suppresses any step due in that cycle.
module amax10_qsys_ledr_seq_tick
    import amax10_qsys_ledr_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    load,
    input  logic                    enable,
    output logic                    step
);

    logic [PERIOD_WIDTH-1:0] r_count;

    assign step = enable && !load && (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load || step) begin
            r_count <= period;
        end else if (enable) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/amax10_qsys_ledr_seq.sv
// Avalon-MM LED sequencer: rotates or bounces a pattern across out_port at a
// programmable step rate. Assumes DATA_WIDTH <= 8 so STATUS fields do not overlap.
module amax10_qsys_ledr_seq
    import amax10_qsys_ledr_seq_pkg::*;
#(
    parameter int unsigned               DATA_WIDTH   = 8,
    parameter logic [PERIOD_WIDTH-1:0]   PERIOD_RESET = PERIOD_RESET_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic [DATA_WIDTH-1:0]   r_pattern;
    logic [CTRL_WIDTH-1:0]   r_ctrl;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [DATA_WIDTH-1:0]   r_work;
    state_e                  r_state;

    state_e                  w_state_d;
    logic [DATA_WIDTH-1:0]   w_work_d;
    logic                    w_wr;
    logic                    w_wr_pattern;
    logic                    w_wr_ctrl;
    logic                    w_wr_period;
    logic                    w_load;
    logic                    w_enable;
    logic                    w_step;
    logic                    w_running;
    logic                    w_unused;

    assign w_wr         = chipselect && !write_n;
    assign w_wr_pattern = w_wr && (address == ADDR_PATTERN);
    assign w_wr_ctrl    = w_wr && (address == ADDR_CTRL);
    assign w_wr_period  = w_wr && (address == ADDR_PERIOD);
    assign w_running    = (r_state != StIdle);
    assign w_unused     = ^writedata[31:PERIOD_WIDTH];

    amax10_qsys_ledr_seq_tick u_tick (
        .clk    (clk),
        .reset  (reset),
        .period (r_period),
        .load   (w_load),
        .enable (w_enable),
        .step   (w_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= '0;
            r_ctrl    <= '0;
            r_period  <= PERIOD_RESET;
            r_work    <= '0;
            r_state   <= StIdle;
        end else begin
            r_work  <= w_work_d;
            r_state <= w_state_d;
            if (w_wr_pattern) r_pattern <= writedata[DATA_WIDTH-1:0];
            if (w_wr_ctrl)    r_ctrl    <= writedata[CTRL_WIDTH-1:0];
            if (w_wr_period)  r_period  <= writedata[PERIOD_WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_work_d  = r_work;
        w_load    = 1'b0;
        w_enable  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_wr_ctrl && writedata[CTRL_RUN]) begin
                    w_state_d = StRunLeft;
                    w_work_d  = r_pattern;
                    w_load    = 1'b1;
                end
            end
            StRunLeft, StRunRight: begin
                w_enable = 1'b1;
                if (w_wr_ctrl && !writedata[CTRL_RUN]) begin
                    w_state_d = StIdle;
                end else if (w_wr_pattern) begin
                    // A new pattern restarts the sequence and takes priority over a due step.
                    w_state_d = StRunLeft;
                    w_work_d  = writedata[DATA_WIDTH-1:0];
                    w_load    = 1'b1;
                end else begin
                    if (!r_ctrl[CTRL_MODE]) w_state_d = StRunLeft;
                    if (w_step) begin
                        if (!r_ctrl[CTRL_MODE]) begin
                            w_work_d = {r_work[DATA_WIDTH-2:0], r_work[DATA_WIDTH-1]};
                        end else if (r_state == StRunLeft) begin
                            if (r_work[DATA_WIDTH-1]) begin
                                w_work_d  = r_work >> 1;
                                w_state_d = StRunRight;
                            end else begin
                                w_work_d = r_work << 1;
                            end
                        end else begin
                            if (r_work[0]) begin
                                w_work_d  = r_work << 1;
                                w_state_d = StRunLeft;
                            end else begin
                                w_work_d = r_work >> 1;
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign out_port = w_running ? r_work : r_pattern;

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_PATTERN: readdata[DATA_WIDTH-1:0]   = r_pattern;
            ADDR_CTRL:    readdata[CTRL_WIDTH-1:0]   = r_ctrl;
            ADDR_PERIOD:  readdata[PERIOD_WIDTH-1:0] = r_period;
            ADDR_STATUS: begin
                readdata[0]              = w_running;
                readdata[1]              = (r_state == StRunRight);
                readdata[8 +: DATA_WIDTH] = out_port;
            end
        endcase
    end

endmodule

// File: tb/tb_amax10_qsys_ledr_seq.sv
// Bench for the LED sequencer: directed scenarios plus a randomized bus phase,
// all checked against an arithmetic reference model of the register/step rules.
module tb_amax10_qsys_ledr_seq;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_checks = 0;
    int n_errors = 0;

    amax10_qsys_ledr_seq dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_pattern = '0;
    logic [1:0]  m_ctrl    = '0;
    logic [23:0] m_period  = 24'h4C4B3F;
    logic [7:0]  m_work    = '0;
    int unsigned m_cnt     = 0;
    bit          m_run     = 1'b0;
    bit          m_right   = 1'b0;

    task automatic model_step();
        int w;
        w = int'(m_work);
        if (!m_ctrl[1]) begin
            w = (w * 2) % 256 + w / 128;
        end else if (!m_right) begin
            if (w >= 128) begin w = w / 2; m_right = 1'b1; end
            else w = (w * 2) % 256;
        end else begin
            if (w % 2 == 1) begin w = (w * 2) % 256; m_right = 1'b0; end
            else w = w / 2;
        end
        m_work = w[7:0];
    endtask

    task automatic model_edge();
        bit wr;
        wr = chipselect && !write_n;
        if (reset) begin
            m_pattern = '0; m_ctrl = '0; m_period = 24'h4C4B3F;
            m_work = '0; m_cnt = 0; m_run = 1'b0; m_right = 1'b0;
            return;
        end
        if (m_run) begin
            if (wr && address == 2'd1 && !writedata[0]) begin
                m_run = 1'b0; m_right = 1'b0;
            end else if (wr && address == 2'd0) begin
                m_work = writedata[7:0]; m_cnt = m_period; m_right = 1'b0;
            end else begin
                if (!m_ctrl[1]) m_right = 1'b0;
                if (m_cnt == 0) begin m_cnt = m_period; model_step(); end
                else m_cnt = m_cnt - 1;
            end
        end else if (wr && address == 2'd1 && writedata[0]) begin
            m_run = 1'b1; m_right = 1'b0; m_work = m_pattern; m_cnt = m_period;
        end
        if (wr) begin
            case (address)
                2'd0:    m_pattern = writedata[7:0];
                2'd1:    m_ctrl    = writedata[1:0];
                2'd2:    m_period  = writedata[23:0];
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] exp_out();
        return m_run ? m_work : m_pattern;
    endfunction

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_pattern};
            2'd1:    return {30'h0, m_ctrl};
            2'd2:    return {8'h0, m_period};
            default: return {16'h0, exp_out(), 6'h0, m_right, m_run};
        endcase
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    endtask

    task automatic bus_cycle(input logic cs, input logic wn, input logic [1:0] a,
                             input logic [31:0] d);
        chipselect = cs; write_n = wn; address = a; writedata = d;
        tick();
        bus_idle();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_cycle(1'b1, 1'b0, a, d);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic check_model_out(input string tag);
        check(tag, {24'h0, out_port}, {24'h0, exp_out()});
    endtask

    initial begin
        reset = 1'b1;
        bus_idle();
        tick();
        // Reset must win over a same-cycle write
        bus_write(2'd0, 32'hFF);
        reset = 1'b0;

        check_reg("rst_pattern", 2'd0, 32'h0);
        check_reg("rst_ctrl",    2'd1, 32'h0);
        check_reg("rst_period",  2'd2, 32'h004C4B3F);
        check_reg("rst_status",  2'd3, 32'h0);
        check("rst_out", {24'h0, out_port}, 32'h0);

        // Rotate, one step per PERIOD+1 = 4 cycles
        bus_write(2'd0, 32'h01);
        bus_write(2'd2, 32'h3);
        bus_write(2'd1, 32'h1);
        check("rot_start", {24'h0, out_port}, 32'h01);
        repeat (3) begin tick(); check("rot_hold", {24'h0, out_port}, 32'h01); end
        tick();
        check("rot_step1", {24'h0, out_port}, 32'h02);
        repeat (28) begin tick(); check_model_out("rot_model"); end
        check("rot_wrap", {24'h0, out_port}, 32'h01);

        bus_write(2'd1, 32'h0);
        check_reg("stop_status", 2'd3, 32'h0000_0100);

        // Bounce at one step per cycle
        bus_write(2'd0, 32'h03);
        bus_write(2'd2, 32'h0);
        bus_write(2'd1, 32'h3);
        check("bnc_start", {24'h0, out_port}, 32'h03);
        for (int k = 1; k <= 13; k++) begin
            tick();
            check_model_out("bnc_model");
            if (k == 6)  check("bnc_c0", {24'h0, out_port}, 32'hC0);
            if (k == 7)  check_reg("bnc_right", 2'd3, 32'h0000_6003);
            if (k == 12) check_reg("bnc_03", 2'd3, 32'h0000_0303);
            if (k == 13) check_reg("bnc_back", 2'd3, 32'h0000_0601);
        end

        // PATTERN write colliding with a due step
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'h01);
        bus_write(2'd2, 32'h5);
        bus_write(2'd1, 32'h1);
        repeat (8) tick();
        for (int i = 0; i < 20 && m_cnt != 0; i++) tick();
        bus_write(2'd0, 32'h55);
        check("col_load", {24'h0, out_port}, 32'h55);
        repeat (5) begin tick(); check("col_hold", {24'h0, out_port}, 32'h55); end
        tick();
        check("col_step", {24'h0, out_port}, 32'hAA);

        // Stop, then reset mid-run
        bus_write(2'd1, 32'h0);
        check_reg("stop2_status", 2'd3, 32'h0000_5500);
        check("stop2_out", {24'h0, out_port}, 32'h55);
        bus_write(2'd1, 32'h1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_out", {24'h0, out_port}, 32'h0);
        check_reg("mid_rst_ctrl", 2'd1, 32'h0);
        repeat (10) tick();
        check_reg("mid_rst_idle", 2'd3, 32'h0);

        // Writes that must be ignored
        bus_write(2'd0, 32'hA5);
        bus_write(2'd2, 32'h7);
        bus_write(2'd1, 32'h2);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_cycle(1'b1, 1'b1, 2'd0, 32'hFF);
        bus_cycle(1'b0, 1'b0, 2'd2, 32'hFF_FFFF);
        bus_cycle(1'b0, 1'b0, 2'd1, 32'h3);
        check_reg("ign_pattern", 2'd0, 32'hA5);
        check_reg("ign_ctrl",    2'd1, 32'h2);
        check_reg("ign_period",  2'd2, 32'h7);
        check_reg("ign_status",  2'd3, 32'h0000_A500);
        check("ign_out", {24'h0, out_port}, 32'hA5);

        // Randomized bus traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                bus_write(2'd0, ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom_range(1, 255)));
            end else if (r < 12) begin
                bus_write(2'd1, {30'h0, 1'($urandom_range(0, 1)),
                                 1'($urandom_range(0, 3) != 0)});
            end else if (r < 16) begin
                bus_write(2'd2, 32'($urandom_range(0, 4)));
            end else if (r < 20) begin
                bus_cycle(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), $urandom);
            end else if (r < 22) begin
                bus_write(2'd3, $urandom);
            end else if (r < 23) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
            check_model_out("rnd_out");
            begin
                logic [1:0] a;
                a = 2'($urandom_range(0, 3));
                check_reg("rnd_read", a, exp_read(a));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/amax10_qsys_ledr_seq.md
AMAX10_QSYS_LEDR_SEQ -- requirements
Module: amax10_qsys_ledr_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, LED output width.
REQ-002 SHALL have parameter PERIOD_RESET, default 24'h4C4B3F, reset step period (0.1 s at 50 MHz).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port address, input, 2, Avalon-MM register select.
REQ-006 SHALL have port chipselect, input, 1, Avalon-MM slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port readdata, output, 32, read data, combinational from address, zero wait states.
REQ-010 SHALL have port out_port, output, DATA_WIDTH, LED drive.

Function
REQ-011 SHALL accept a write when chipselect=1 and write_n=0; register updates on that clock edge.
REQ-012 SHALL map registers: 0 PATTERN[7:0] R/W; 1 CTRL (bit0 RUN, bit1 MODE: 0 rotate, 1 bounce) R/W; 2 PERIOD[23:0] R/W; 3 STATUS read-only, writes ignored.
REQ-013 SHALL return STATUS as bit0 running, bit1 direction (1 = right), bits15:8 current out_port, all other bits 0; unused register bits read 0.
REQ-014 SHALL implement states IDLE, RUN_LEFT, RUN_RIGHT.
REQ-015 SHALL drive out_port = PATTERN in IDLE and = working register WORK in RUN_LEFT/RUN_RIGHT.
REQ-016 SHALL, on a write setting RUN=1 from IDLE, load WORK=PATTERN and tick counter=PERIOD, and enter RUN_LEFT next cycle.
REQ-017 SHALL decrement the tick counter each cycle while running; at 0, perform one step and reload PERIOD, giving one step every PERIOD+1 cycles; PERIOD=0 steps every cycle.
REQ-018 SHALL, in rotate mode, step WORK by rotate-left 1; state RUN_LEFT.
REQ-019 SHALL, in bounce mode, in RUN_LEFT: if WORK[7]=1 shift right logical 1 and go RUN_RIGHT, else shift left logical 1; in RUN_RIGHT: if WORK[0]=1 shift left 1 and go RUN_LEFT, else shift right 1.
REQ-020 SHALL, on MODE change to rotate while in RUN_RIGHT, go RUN_LEFT and rotate left at the next step.
REQ-021 SHALL, on a write clearing RUN, enter IDLE next cycle; out_port shows PATTERN from that cycle.
REQ-022 SHALL, on a PATTERN write while running, reload WORK=new pattern and counter=PERIOD and set RUN_LEFT; this write wins over a step in the same cycle.
REQ-023 SHALL apply a PERIOD write at the next counter reload; current count is not disturbed.
REQ-024 SHALL keep WORK=0 unchanged at steps when PATTERN=0, with no state change.

Reset
REQ-025 SHALL, with reset=1 at a clock edge, set PATTERN=0, CTRL=0, PERIOD=PERIOD_RESET, WORK=0, counter=0, state IDLE, out_port=0; reset overrides any same-cycle write.
REQ-026 SHALL, on reset mid-run, give out_port=0 on the cycle after the reset edge and stay IDLE until RUN is rewritten.

Structure
REQ-027 SHALL place register address constants, CTRL bit indices, state enumeration and PERIOD_RESET default in package amax10_qsys_ledr_seq_pkg.
REQ-028 SHALL implement the down-counter/reload as sub-module amax10_qsys_ledr_seq_tick (inputs period, load, enable; output step pulse).

Verification
REQ-029 SHALL cover: reset, then read all four addresses -> 0, 0, 0x004C4B3F, 0; out_port=0.
REQ-030 SHALL cover: PATTERN=0x01, PERIOD=3, CTRL=0x1 -> out_port 0x01,0x02,0x04... changing every 4 cycles, 0x80 wraps to 0x01.
REQ-031 SHALL cover: PATTERN=0x03, PERIOD=0, CTRL=0x3 -> 0x03,0x06,...,0xC0,0x60,...,0x03,0x06 one per cycle; STATUS bit1 set during rightward run.
REQ-032 SHALL cover: running, write PATTERN=0x55 in the same cycle a step is due -> WORK=0x55, next step exactly PERIOD+1 cycles later.
REQ-033 SHALL cover: running, write CTRL=0 -> next cycle STATUS=0x0000_xx00 with out_port=PATTERN; assert reset mid-run -> out_port=0, CTRL=0.
REQ-034 SHALL cover: write address 3 with 0xFFFFFFFF, or write with write_n=1 or chipselect=0 -> no register change.
